uart_rx: RTL

Asynchronous serial receiver, the receive-side counterpart of `uart_tx`. It takes the raw `rx` line, synchronises it, and detects start bits. It samples each bit at mid-bit using the same `BAUD_CNT` clocks-per-bit convention as `uart_tx`, then presents each received byte as a one-cycle valid pulse. It sits at the pin boundary of any UART application block, typically paired with `uart_tx` for a loopback or command link.

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_rx_sync.sv | 15 +
 rtl/uart_rx.sv | 104 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and defaults for uart_rx and uart_tx.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
    localparam int UART_DATA_W = 8;
    localparam int UART_BAUD_CNT_DEFAULT = 434;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser plus history flop; flags a fresh 1->0 transition on rx.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall
);
    logic s1, s2, h;
    always_ff @(posedge clk or negedge rst)
        if (!rst) {s1, s2, h} <= 3'b111;
        else {s1, s2, h} <= {rx, s1, s2};
    assign rx_s = s2;
    assign fall = h & ~s2;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: mid-bit sampling UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_CNT = UART_BAUD_CNT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   frame_err,
    output logic                   parity_err,
    output logic                   busy
);
    localparam int CW = $clog2(BAUD_CNT);
    localparam logic [CW-1:0] HALF = CW'(BAUD_CNT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(BAUD_CNT - 1);

    logic                   rx_s, fall, par_ok;
    logic [CW-1:0]          cnt;
    logic [UART_DATA_W-1:0] sh;
    logic [2:0]             idx;
    uart_state_t            state;

    uart_rx_sync u_sync (.clk(clk), .rst(rst), .rx(rx), .rx_s(rx_s), .fall(fall));

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    assign par_ok = ~^{sh, par_bit};
`else
    assign par_ok = 1'b1;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sh        <= '0;
            idx       <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (fall) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: if (cnt == HALF) begin
                    cnt   <= '0;
                    state <= rx_s ? IDLE : DATA;
                    busy  <= ~rx_s;
                end else cnt <= cnt + 1'b1;
                DATA: if (cnt == FULL) begin
                    cnt <= '0;
                    sh  <= {rx_s, sh[UART_DATA_W-1:1]};
                    idx <= idx + 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (idx == 3'd7) state <= PARITY;
`else
                    if (idx == 3'd7) state <= STOP;
`endif
                end else cnt <= cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
                PARITY: if (cnt == FULL) begin
                    cnt     <= '0;
                    par_bit <= rx_s;
                    state   <= STOP;
                end else cnt <= cnt + 1'b1;
`endif
                STOP: if (cnt == FULL) begin
                    cnt       <= '0;
                    state     <= IDLE;
                    busy      <= 1'b0;
                    frame_err <= ~rx_s;
                    if (rx_s && par_ok) begin
                        rx_data  <= sh;
                        rx_valid <= 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
                    parity_err <= ~par_ok;
`endif
                end else cnt <= cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
